mcm_responder: RTL and testbench
================================

# mcm_responder

Multi-cycle, fully pipelined main-memory responder: the memory side of the request/`data_valid` interface used by the I-cache and D-cache fill logic. It accepts one word request per cycle. Writes commit in one cycle. Read data returns exactly `LATENCY` cycles after acceptance, flagged by `data_valid`, so an 8-word cache-block fill can be issued back-to-back and returned back-to-back. It sits behind the cache arbitration mux in `cpu` and is the standalone, parameterised replacement for the fixed 4-cycle memory model.

## Interface
- `ADDR_WIDTH`, default 16: byte-address width. Storage is 2^(ADDR_WIDTH-1) 16-bit words.
- `LATENCY`, default 4: read latency in cycles. Legal range is 1..15.
- `clk` input, 1: single clock, rising-edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `enable` input, 1: a request is present this cycle.
- `wr` input, 1: qualifies `enable`. 1 = write, 0 = read.
- `addr` input, ADDR_WIDTH: byte address. Bit 0 is ignored; the word index is `addr[ADDR_WIDTH-1:1]`.
- `data_in` input, 16: write data.
- `data_out` output, 16: read data. Valid only when `data_valid` is 1; forced to 0 otherwise.
- `data_valid` output, 1: one-cycle pulse per completed read.
- `busy` output, 1: at least one read is in flight, counting the completion cycle.
- `rd_outstanding` output, 4: number of reads accepted whose `data_valid` cycle has not yet passed. Range 0..LATENCY.

## Operation
- **Request acceptance.** A request is accepted at every rising edge where `enable`=1. There is no backpressure and no ready signal. `wr` and `addr` are don't-care when `enable`=0.
- **Write** (`enable`=1, `wr`=1):
  - `mem[addr[ADDR_WIDTH-1:1]] <= data_in` at the accepting edge.
  - No `data_valid` pulse is produced.
  - The write does not enter the read pipeline.
- **Read** (`enable`=1, `wr`=0):
  - The word is read from the array at the accepting edge and captured into pipeline stage 1.
  - The captured value reflects all writes accepted at earlier edges.
  - A write in the same cycle is impossible, since there is one request per cycle.
- **Read pipeline.**
  - `LATENCY` stages, each holding {valid, 16-bit data}, shifting every cycle unconditionally.
  - The last stage drives `data_out`/`data_valid`.
  - Stage data is zeroed when its valid bit is 0, so `data_out`=0 whenever `data_valid`=0.
- **Ordering.** Reads complete in acceptance order. Reads and writes are not reordered: a read accepted after a write to the same word returns the written data, even while earlier reads are still in flight.
- **`rd_outstanding` counter.**
  - +1 on an accepted read.
  - −1 on the edge ending a `data_valid` cycle.
  - Both events in the same cycle: net 0.
  - It never exceeds LATENCY, because one read is accepted per cycle.
- **`busy`** = (`rd_outstanding` != 0).
- **Reset.** Asynchronous assertion of `rst_n`=0 immediately clears:
  - all stage valid/data bits;
  - `data_valid`=0, `data_out`=0;
  - `rd_outstanding`=0, `busy`=0.

  In-flight reads are discarded and never produce `data_valid`. Array contents are NOT reset and retain prior writes. While `rst_n`=0, requests are ignored, including writes.
- **Address wrap.** None. The address maps directly to a word; odd addresses alias the even word below them.

## Timing
- Cycle n is the cycle in which `enable`=1 is presented (sampled at the edge ending cycle n).
- Read issued in cycle n: `data_valid`=1 and `data_out` = word during cycle n+LATENCY only.
- Back-to-back reads in cycles n..n+k: `data_valid` is high for cycles n+LATENCY..n+LATENCY+k, with one word per cycle in issue order.
- Write in cycle n, read of the same word in cycle n+1: the read returns the new data in cycle n+1+LATENCY.
- `rd_outstanding` is registered: it reads 1 in cycle n+1 after a single read in cycle n, and returns to 0 in cycle n+LATENCY+1.
- Reset release: the first request is accepted at the first rising edge with `rst_n`=1 sampled high. Outputs are 0 until then.

## Test plan
- **Reset state.**
  - Stimulus: assert `rst_n`=0 mid-cycle.
  - Required: `data_valid`, `data_out`, `busy`, `rd_outstanding` all 0 immediately (asynchronously), before any clock edge.
- **Single read, LATENCY=4.**
  - Stimulus: write 0xBEEF to addr 0x0010 in cycle 0; read addr 0x0010 in cycle 1.
  - Required: `data_valid`=1 with `data_out`=0xBEEF in cycle 5 only.
  - Required: `rd_outstanding`=1 in cycles 2..5, 0 in cycle 6.
- **Block fill.**
  - Stimulus: preload words 0x0100+2i = 0x1000+i for i=0..7; issue 8 consecutive reads 0x0100..0x010E in cycles 0..7.
  - Required: `data_valid` high in cycles 4..11 with data 0x1000..0x1007 in order.
  - Required: `rd_outstanding` peaks at 4.
- **Interleaved write/read with idle gaps.**
  - Stimulus: read A(=0x1111); write A=0x2222; idle cycle; read A.
  - Required: first return 0x1111, second return 0x2222. The write produces no `data_valid`. `data_out`=0 in non-valid cycles.
- **Reset mid-flight.**
  - Stimulus: three reads issued in cycles 0..2; `rst_n` pulsed low in cycle 3; released in cycle 4.
  - Required: no `data_valid` ever for those reads. A read of a previously written word after release returns that word, confirming the array is preserved.
- **Aliasing and parameters.**
  - Stimulus: write 0xA5A5 to addr 0x0021, then read addr 0x0020.
  - Required: read returns 0xA5A5.
  - Repeat the single-read test with LATENCY=1 (valid in cycle n+1) and LATENCY=15 (valid in cycle n+15).

Source files
------------

// File: rtl/mcm_responder.sv
`default_nettype none
// ============================================================================
// Module      : mcm_responder
// Description : Fully pipelined main-memory responder. Accepts one word
//               request per cycle; writes commit at the accepting edge and
//               reads return exactly LATENCY cycles later with a one-cycle
//               data_valid pulse. Tracks the number of reads in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module mcm_responder #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           data_in,
    output logic [15:0]           data_out,
    output logic                  data_valid,
    output logic                  busy,
    output logic [3:0]            rd_outstanding
);

    // Word-addressed storage: byte address bit 0 is dropped.
    localparam int IDX_W = ADDR_WIDTH - 1;
    localparam int DEPTH = 1 << IDX_W;

    logic [15:0]      mem_q [DEPTH];
    logic [IDX_W-1:0] word_idx;
    logic [15:0]      rd_word;
    logic             wr_en;
    logic             rd_en;
    logic             unused_addr_lsb;

    // Read pipeline: stage 0 is loaded at the accepting edge, the last
    // stage drives the outputs.
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [15:0]        dat_q [LATENCY];
    logic [15:0]        dat_d [LATENCY];

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign word_idx        = addr[ADDR_WIDTH-1:1];
    assign unused_addr_lsb = addr[0];

    // Writes are suppressed while reset is held so the array never takes a
    // request that arrives during reset; reads are discarded by the pipeline
    // reset instead.
    assign wr_en = enable & wr & rst_n;
    assign rd_en = enable & ~wr;

    // One request per cycle means no write can coincide with a read, so
    // the array value seen here already includes every earlier write.
    assign rd_word = mem_q[word_idx];

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[word_idx] <= data_in;
        end
    end

    // Next-state of the read pipeline; data is zeroed on empty slots so the
    // output bus is 0 whenever data_valid is low.
    always_comb begin
        vld_d[0] = rd_en;
        dat_d[0] = rd_en ? rd_word : 16'h0000;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Outstanding-read count: +1 on accept, -1 as the completion cycle ends.
    always_comb begin
        cnt_d = cnt_q;
        case ({rd_en, vld_q[LATENCY-1]})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pipeline and counter registers, cleared asynchronously on reset so
    // in-flight reads are dropped without producing data_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= 16'h0000;
            end
            cnt_q <= 4'd0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= dat_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    assign data_valid     = vld_q[LATENCY-1];
    assign data_out       = dat_q[LATENCY-1];
    assign rd_outstanding = cnt_q;
    assign busy           = (cnt_q != 4'd0);

endmodule
`default_nettype wire

// File: tb/tb_mcm_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mcm_responder
// Description : Directed self-checking bench for mcm_responder. Three
//               instances (LATENCY 4, 1, 15) share one request stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcm_responder;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;

    logic [15:0] dout [3];
    logic        dv   [3];
    logic        bsy  [3];
    logic [3:0]  ro   [3];

    int lat [3] = '{4, 1, 15};

    int n_checks = 0;
    int n_errors = 0;

    mcm_responder #(.ADDR_WIDTH(16), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(dout[0]), .data_valid(dv[0]),
        .busy(bsy[0]), .rd_outstanding(ro[0])
    );

    mcm_responder #(.ADDR_WIDTH(16), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(dout[1]), .data_valid(dv[1]),
        .busy(bsy[1]), .rd_outstanding(ro[1])
    );

    mcm_responder #(.ADDR_WIDTH(16), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(dout[2]), .data_valid(dv[2]),
        .busy(bsy[2]), .rd_outstanding(ro[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    // Advance to just after the next rising edge (start of next cycle).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int peak;

    initial begin
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 16'h0000, 16'h0000);

        // ---------------- Reset state (asynchronous) ----------------
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst L%0d dv", lat[k]),   dv[k],   32'd0);
            check($sformatf("rst L%0d dout", lat[k]), dout[k], 32'd0);
            check($sformatf("rst L%0d busy", lat[k]), bsy[k],  32'd0);
            check($sformatf("rst L%0d ro", lat[k]),   ro[k],   32'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;

        // ---------------- Single read, all latencies ----------------
        apply(1'b1, 1'b1, 16'h0010, 16'hBEEF);   // cycle 0
        tick();
        apply(1'b1, 1'b0, 16'h0010, 16'h0000);   // cycle 1
        tick();
        apply(1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int c = 2; c <= 17; c++) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("single L%0d c%0d dv", lat[k], c), dv[k], (c == 1 + lat[k]) ? 32'd1 : 32'd0);
                check($sformatf("single L%0d c%0d dout", lat[k], c), dout[k], (c == 1 + lat[k]) ? 32'hBEEF : 32'h0);
                check($sformatf("single L%0d c%0d ro", lat[k], c), ro[k], (c >= 2 && c <= 1 + lat[k]) ? 32'd1 : 32'd0);
                check($sformatf("single L%0d c%0d busy", lat[k], c), bsy[k], (c >= 2 && c <= 1 + lat[k]) ? 32'd1 : 32'd0);
            end
            tick();
        end

        // ---------------- Block fill (LATENCY=4) ----------------
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 1'b1, 16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
            tick();
        end
        peak = 0;
        for (int c = 0; c <= 12; c++) begin
            if (c < 8) apply(1'b1, 1'b0, 16'h0100 + 16'(2 * c), 16'h0000);
            else       apply(1'b0, 1'b0, 16'h0000, 16'h0000);
            check($sformatf("fill c%0d dv", c), dv[0], (c >= 4 && c <= 11) ? 32'd1 : 32'd0);
            check($sformatf("fill c%0d dout", c), dout[0], (c >= 4 && c <= 11) ? 32'h1000 + 32'(c - 4) : 32'h0);
            if (int'(ro[0]) > peak) peak = int'(ro[0]);
            tick();
        end
        check("fill ro peak", 32'(peak), 32'd4);
        check("fill ro drained", ro[0], 32'd0);

        // ---------------- Interleaved write/read with gap ----------------
        apply(1'b1, 1'b1, 16'h0200, 16'h1111);   // preload A
        tick();
        for (int c = 0; c <= 8; c++) begin
            case (c)
                0:       apply(1'b1, 1'b0, 16'h0200, 16'h0000);
                1:       apply(1'b1, 1'b1, 16'h0200, 16'h2222);
                3:       apply(1'b1, 1'b0, 16'h0200, 16'h0000);
                default: apply(1'b0, 1'b0, 16'h0000, 16'h0000);
            endcase
            check($sformatf("ilv c%0d dv", c), dv[0], (c == 4 || c == 7) ? 32'd1 : 32'd0);
            check($sformatf("ilv c%0d dout", c), dout[0],
                  (c == 4) ? 32'h1111 : (c == 7) ? 32'h2222 : 32'h0);
            tick();
        end

        // ---------------- Reset mid-flight ----------------
        apply(1'b1, 1'b1, 16'h0300, 16'h3C3C);   // preload B
        tick();
        for (int c = 0; c < 3; c++) begin
            apply(1'b1, 1'b0, 16'h0100, 16'h0000);
            tick();
        end
        // cycle 3: write presented but reset is low at its edge
        check("mid pre-reset ro", ro[0], 32'd3);
        apply(1'b1, 1'b1, 16'h0300, 16'hDEAD);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid async dv", dv[0], 32'd0);
        check("mid async ro", ro[0], 32'd0);
        check("mid async busy", bsy[0], 32'd0);
        tick();
        // cycle 4: release
        rst_n = 1'b1;
        apply(1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int c = 4; c <= 10; c++) begin
            if (c == 5) apply(1'b1, 1'b0, 16'h0300, 16'h0000);
            else        apply(1'b0, 1'b0, 16'h0000, 16'h0000);
            check($sformatf("mid c%0d dv", c), dv[0], (c == 9) ? 32'd1 : 32'd0);
            check($sformatf("mid c%0d dout", c), dout[0], (c == 9) ? 32'h3C3C : 32'h0);
            tick();
        end

        // ---------------- Odd address aliasing ----------------
        apply(1'b1, 1'b1, 16'h0021, 16'hA5A5);   // cycle 0
        tick();
        apply(1'b1, 1'b0, 16'h0020, 16'h0000);   // cycle 1
        tick();
        apply(1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int c = 2; c <= 6; c++) begin
            check($sformatf("alias c%0d dv", c), dv[0], (c == 5) ? 32'd1 : 32'd0);
            check($sformatf("alias c%0d dout", c), dout[0], (c == 5) ? 32'hA5A5 : 32'h0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
